x_mem_arb: RTL and testbench

X_MEM_ARB -- requirements
Module: x_mem_arb

---
 rtl/x_mem_arb_pkg.sv | 19 +
 rtl/x_sat_cnt.sv | 35 +++
 rtl/x_mem_arb.sv | 133 +++++++++++++
 tb/tb_x_mem_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/x_mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package x_mem_arb_pkg;

  // Default width of the per-requester accept counters.
  localparam int unsigned CntWDefault = 16;

  // Arbiter state: idle, or granted to requester 0 or 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_sm_t;

  // Grant state for a requester index.
  function automatic arb_sm_t gnt_of(input logic sel);
    return sel ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/x_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module x_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/x_mem_arb.sv
// Two-requester memory arbiter with alternating priority and zero-bubble
// handover. Request fields pass through combinationally from the granted
// requester; only the grant state and priority pointer are registered.
module x_mem_arb
  import x_mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_m0_valid,
  input  logic             i_m0_rnw,
  input  logic [31:0]      i_m0_addr,
  input  logic [31:0]      i_m0_data,
  output logic             o_m0_accept,
  output logic [31:0]      o_m0_data,
  input  logic             i_m1_valid,
  input  logic             i_m1_rnw,
  input  logic [31:0]      i_m1_addr,
  input  logic [31:0]      i_m1_data,
  output logic             o_m1_accept,
  output logic [31:0]      o_m1_data,
  output logic             o_valid,
  output logic             o_rnw,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_data,
  input  logic             i_accept,
  input  logic [31:0]      i_data,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_m0_cnt,
  output logic [CNT_W-1:0] o_m1_cnt
);

  arb_sm_t state_d, state_q;
  logic    prio_d, prio_q;

  // Next grant and priority; withdrawal returns to IDLE without touching prio.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (i_m0_valid && i_m1_valid) begin
          state_d = gnt_of(prio_q);
        end else if (i_m0_valid) begin
          state_d = GNT0;
        end else if (i_m1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!i_m0_valid) begin
          state_d = IDLE;
        end else if (i_accept) begin
          prio_d  = 1'b1;
          state_d = i_m1_valid ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!i_m1_valid) begin
          state_d = IDLE;
        end else if (i_accept) begin
          prio_d  = 1'b0;
          state_d = i_m0_valid ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant state and priority pointer.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Route the granted requester downstream; accept only while it is still valid.
  always_comb begin
    o_valid     = 1'b0;
    o_rnw       = 1'b0;
    o_addr      = '0;
    o_data      = '0;
    o_m0_accept = 1'b0;
    o_m1_accept = 1'b0;
    unique case (state_q)
      GNT0: begin
        o_valid     = i_m0_valid;
        o_rnw       = i_m0_rnw;
        o_addr      = i_m0_addr;
        o_data      = i_m0_data;
        o_m0_accept = i_accept & i_m0_valid;
      end
      GNT1: begin
        o_valid     = i_m1_valid;
        o_rnw       = i_m1_rnw;
        o_addr      = i_m1_addr;
        o_data      = i_m1_data;
        o_m1_accept = i_accept & i_m1_valid;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each requester qualifies it with its own accept.
  assign o_m0_data = i_data;
  assign o_m1_data = i_data;

  x_sat_cnt #(
    .W (CNT_W)
  ) u_m0_cnt (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .clr_i  (i_cnt_clr),
    .inc_i  (o_m0_accept),
    .cnt_o  (o_m0_cnt)
  );

  x_sat_cnt #(
    .W (CNT_W)
  ) u_m1_cnt (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .clr_i  (i_cnt_clr),
    .inc_i  (o_m1_accept),
    .cnt_o  (o_m1_cnt)
  );

endmodule

// File: tb/tb_x_mem_arb.sv
// Directed self-checking bench for x_mem_arb (counters narrowed to 4 bits).
module tb_x_mem_arb;

  localparam int unsigned CntW  = 4;
  localparam logic [31:0] AddrA = 32'h0000_0100;
  localparam logic [31:0] AddrB = 32'h0000_0200;

  logic            clk, nrst;
  logic            m0_valid, m0_rnw, m1_valid, m1_rnw;
  logic [31:0]     m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic            m0_accept, m1_accept;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            d_valid, d_rnw, d_accept, cnt_clr;
  logic [31:0]     d_addr, d_wdata, d_rdata;
  logic [CntW-1:0] m0_cnt, m1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  x_mem_arb #(
    .CNT_W (CntW)
  ) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_m0_valid  (m0_valid),
    .i_m0_rnw    (m0_rnw),
    .i_m0_addr   (m0_addr),
    .i_m0_data   (m0_wdata),
    .o_m0_accept (m0_accept),
    .o_m0_data   (m0_rdata),
    .i_m1_valid  (m1_valid),
    .i_m1_rnw    (m1_rnw),
    .i_m1_addr   (m1_addr),
    .i_m1_data   (m1_wdata),
    .o_m1_accept (m1_accept),
    .o_m1_data   (m1_rdata),
    .o_valid     (d_valid),
    .o_rnw       (d_rnw),
    .o_addr      (d_addr),
    .o_data      (d_wdata),
    .i_accept    (d_accept),
    .i_data      (d_rdata),
    .i_cnt_clr   (cnt_clr),
    .o_m0_cnt    (m0_cnt),
    .o_m1_cnt    (m1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_valid = 1'b0; m0_rnw = 1'b0; m0_addr = AddrA; m0_wdata = 32'h0;
    m1_valid = 1'b0; m1_rnw = 1'b0; m1_addr = AddrB; m1_wdata = 32'h0;
    d_accept = 1'b0; d_rdata = 32'h0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    nrst = 1'b0;
    #3;
    check("rst_valid", {31'b0, d_valid}, 32'h0);
    check("rst_accepts", {30'b0, m0_accept, m1_accept}, 32'h0);
    check("rst_addr", d_addr, 32'h0);
    check("rst_cnts", {24'b0, m0_cnt, m1_cnt}, 32'h0);
    do_reset();

    // Single m0 read, accepted on the second grant cycle.
    m0_valid = 1'b1; m0_rnw = 1'b1;
    #1 check("rd_idle_no_grant", {31'b0, d_valid}, 32'h0);
    step();
    check("rd_gnt_valid", {31'b0, d_valid}, 32'h1);
    check("rd_gnt_addr", d_addr, AddrA);
    check("rd_gnt_rnw", {31'b0, d_rnw}, 32'h1);
    check("rd_gnt_no_acc", {31'b0, m0_accept}, 32'h0);
    step();
    d_accept = 1'b1; d_rdata = 32'hDEAD_BEEF;
    #1;
    check("rd_acc", {30'b0, m0_accept, m1_accept}, 32'h2);
    check("rd_data0", m0_rdata, 32'hDEAD_BEEF);
    check("rd_data1", m1_rdata, 32'hDEAD_BEEF);
    step();
    clear_inputs();
    #1;
    check("rd_idle_after", {31'b0, d_valid}, 32'h0);
    check("rd_cnt", {24'b0, m0_cnt, m1_cnt}, 32'h10);

    // Both valid from reset: m0 first, m1 with no bubble, then prio back to m0.
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1; m1_wdata = 32'h55;
    step();
    check("both_first_addr", d_addr, AddrA);
    d_accept = 1'b1;
    #1 check("both_m0_acc", {30'b0, m0_accept, m1_accept}, 32'h2);
    step();
    m0_valid = 1'b0;
    #1;
    check("both_handover_valid", {31'b0, d_valid}, 32'h1);
    check("both_handover_addr", d_addr, AddrB);
    check("both_handover_wdata", d_wdata, 32'h55);
    check("both_handover_rnw", {31'b0, d_rnw}, 32'h0);
    check("both_m1_acc", {30'b0, m0_accept, m1_accept}, 32'h1);
    step();
    clear_inputs();
    #1 check("both_idle", {31'b0, d_valid}, 32'h0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    step();
    check("both_prio_back_m0", d_addr, AddrA);
    clear_inputs();
    step();

    // Both held valid, accept every grant cycle: m0,m1,m0,m1.
    do_reset();
    m0_valid = 1'b1; m1_valid = 1'b1;
    step();
    d_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr_acc%0d", i), {30'b0, m0_accept, m1_accept},
               (i % 2 == 0) ? 32'h2 : 32'h1);
      step();
    end
    clear_inputs();
    #1 check("rr_cnts", {24'b0, m0_cnt, m1_cnt}, 32'h22);
    step();

    // Set prio to 1, then m1 withdraws: IDLE, no accept, prio kept at 1.
    do_reset();
    m0_valid = 1'b1;
    step();
    d_accept = 1'b1;
    step();
    clear_inputs();
    m1_valid = 1'b1;
    step();
    check("wd_gnt_addr", d_addr, AddrB);
    m1_valid = 1'b0; d_accept = 1'b1;
    #1;
    check("wd_valid_drop", {31'b0, d_valid}, 32'h0);
    check("wd_no_acc", {30'b0, m0_accept, m1_accept}, 32'h0);
    step();
    d_accept = 1'b0;
    #1;
    check("wd_idle", {31'b0, d_valid}, 32'h0);
    check("wd_cnts", {24'b0, m0_cnt, m1_cnt}, 32'h10);
    m0_valid = 1'b1; m1_valid = 1'b1;
    step();
    check("wd_prio_kept", d_addr, AddrB);
    clear_inputs();
    step();
    step();

    // Saturation with 4-bit counters, then clear beating an increment.
    do_reset();
    m0_valid = 1'b1; d_accept = 1'b1;
    for (int i = 0; i < 34; i++) step();
    check("sat_cnt", {28'b0, m0_cnt}, 32'hF);
    step();
    #1 check("sat_acc_again", {31'b0, m0_accept}, 32'h1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    #1 check("clr_cnts", {24'b0, m0_cnt, m1_cnt}, 32'h0);
    clear_inputs();
    step();

    // Reset during an accepting grant abandons the access at once.
    do_reset();
    m0_valid = 1'b1; d_accept = 1'b1;
    step();
    step();
    step();
    check("rg_pre_acc", {31'b0, m0_accept}, 32'h1);
    check("rg_pre_cnt", {28'b0, m0_cnt}, 32'h1);
    nrst = 1'b0;
    #1;
    check("rg_valid", {31'b0, d_valid}, 32'h0);
    check("rg_acc", {31'b0, m0_accept}, 32'h0);
    check("rg_cnt", {28'b0, m0_cnt}, 32'h0);
    step();
    clear_inputs();
    nrst = 1'b1;
    step();
    check("rg_after_valid", {31'b0, d_valid}, 32'h0);
    check("rg_after_cnts", {24'b0, m0_cnt, m1_cnt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
